// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 Set-2 scan-code decoder.
`timescale 1ns/1ps

package ps2_pkg;

    // Decoder sequence state
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } state_t;

    localparam logic [7:0] CODE_E0    = 8'hE0;
    localparam logic [7:0] CODE_F0    = 8'hF0;
    localparam logic [7:0] CODE_E1    = 8'hE1;
    localparam logic [7:0] CODE_PAUSE = 8'hE1;

    // Bytes following E1 before the Pause event is emitted
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // One decoded key event
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } event_t;

    // Keyboard status/ack bytes that never form part of a key sequence
    function automatic logic is_discard(input logic [7:0] b);
        logic hit;
        case (b)
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hFC, 8'h00, 8'hFF: hit = 1'b1;
            default:                                         hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead event FIFO with registered head; flags pushes dropped while full.
`timescale 1ns/1ps

module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  event_t din,
    input  logic   pop,
    output logic   valid,
    output event_t dout,
    output logic   drop_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    event_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_next;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_n;
    logic            full_c;
    logic            pop_c;
    logic            push_c;

    assign full_c  = (count == CW'(DEPTH));
    assign pop_c   = pop & valid;
    assign push_c  = push & (~full_c | pop_c);
    assign drop_c  = push & full_c & ~pop_c;
    assign rd_next = rd_ptr + AW'(1);

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_n = count;
        case ({push_c, pop_c})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, count and the registered head entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            dout   <= '0;
        end else begin
            count <= count_n;
            valid <= (count_n != '0);
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_next;
            end
            // New entry becomes head when it lands in an empty (or emptying) FIFO
            if (push_c && ((count == '0) || (pop_c && (count == CW'(1))))) begin
                dout <= din;
            end else if (pop_c) begin
                dout <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: collapses E0/F0/E1 sequences into key events.
// Optional build macro: KEYDEC_TYPEMATIC_FILTER_EN suppresses repeated makes
// of a held key until its break is seen.
`timescale 1ns/1ps

module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       scan_ready,
    input  logic [7:0] scan_code,
    input  logic       ev_read,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_release,
    output logic       ev_overflow
);

    state_t     state;
    state_t     state_n;
    logic [2:0] pause_cnt;
    logic [2:0] pause_cnt_n;
    logic       sr_q;
    logic       accept_c;
    logic       emit_c;
    logic       push_c;
    logic       drop_c;
    event_t     ev_c;
    event_t     head;

    assign accept_c = scan_ready & ~sr_q;

    // Edge detect on the raw driver's ready level
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sr_q <= 1'b0;
        end else begin
            sr_q <= scan_ready;
        end
    end

    // Sequence decode: next state and the event emitted by the accepted byte
    always_comb begin
        state_n     = state;
        pause_cnt_n = pause_cnt;
        emit_c      = 1'b0;
        ev_c        = '{code: scan_code, ext: 1'b0, rel: 1'b0};
        if (accept_c) begin
            case (state)
                ST_IDLE: begin
                    if (scan_code == CODE_E0) begin
                        state_n = ST_EXT;
                    end else if (scan_code == CODE_F0) begin
                        state_n = ST_BRK;
                    end else if (scan_code == CODE_E1) begin
                        state_n     = ST_PAUSE;
                        pause_cnt_n = PAUSE_SKIP;
                    end else if (!is_discard(scan_code)) begin
                        emit_c = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (scan_code == CODE_F0) begin
                        state_n = ST_EXT_BRK;
                    end else if (scan_code != CODE_E0) begin
                        emit_c   = 1'b1;
                        ev_c.ext = 1'b1;
                        state_n  = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    emit_c   = 1'b1;
                    ev_c.rel = 1'b1;
                    state_n  = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    emit_c   = 1'b1;
                    ev_c.ext = 1'b1;
                    ev_c.rel = 1'b1;
                    state_n  = ST_IDLE;
                end
                ST_PAUSE: begin
                    if (pause_cnt == 3'd1) begin
                        emit_c      = 1'b1;
                        ev_c.code   = CODE_PAUSE;
                        pause_cnt_n = 3'd0;
                        state_n     = ST_IDLE;
                    end else begin
                        pause_cnt_n = pause_cnt - 3'd1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Sequence state register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pause_cnt <= 3'd0;
        end else begin
            state     <= state_n;
            pause_cnt <= pause_cnt_n;
        end
    end

`ifdef KEYDEC_TYPEMATIC_FILTER_EN
    logic       hold_valid;
    logic [7:0] hold_code;
    logic       hold_ext;
    logic       hold_match_c;

    assign hold_match_c = hold_valid && (hold_code == ev_c.code) && (hold_ext == ev_c.ext);
    assign push_c       = emit_c & ~(~ev_c.rel & hold_match_c);

    // Track the currently held key; its break releases the hold
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_code  <= 8'h00;
            hold_ext   <= 1'b0;
        end else if (emit_c) begin
            if (!ev_c.rel) begin
                hold_valid <= 1'b1;
                hold_code  <= ev_c.code;
                hold_ext   <= ev_c.ext;
            end else if (hold_match_c) begin
                hold_valid <= 1'b0;
            end
        end
    end
`else
    assign push_c = emit_c;
`endif

    ps2_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (CLOCK_50),
        .rst    (reset),
        .push   (push_c),
        .din    (ev_c),
        .pop    (ev_read),
        .valid  (ev_valid),
        .dout   (head),
        .drop_c (drop_c)
    );

    assign ev_code    = head.code;
    assign ev_ext     = head.ext;
    assign ev_release = head.rel;

    // Sticky record of any event lost to a full FIFO
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            ev_overflow <= 1'b0;
        end else if (drop_c) begin
            ev_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder (DEPTH=4).
`timescale 1ns/1ps

module tb_ps2_scancode_decoder;
    import ps2_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scan_ready = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       ev_read = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_release;
    logic       ev_overflow;

    int checks = 0;
    int errors = 0;
    event_t got_q[$];

    always #5 clk = ~clk;

    ps2_scancode_decoder #(.DEPTH(DEPTH)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .scan_ready  (scan_ready),
        .scan_code   (scan_code),
        .ev_read     (ev_read),
        .ev_valid    (ev_valid),
        .ev_code     (ev_code),
        .ev_ext      (ev_ext),
        .ev_release  (ev_release),
        .ev_overflow (ev_overflow)
    );

    task automatic do_reset();
        @(negedge clk);
        scan_ready = 1'b0;
        ev_read    = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        scan_ready = 1'b1;
        scan_code  = b;
        @(negedge clk);
        scan_ready = 1'b0;
    endtask

    // Pop everything currently buffered into got_q (bounded)
    task automatic drain();
        event_t e;
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            @(negedge clk);
            if (!ev_valid) break;
            e = '{code: ev_code, ext: ev_ext, rel: ev_release};
            got_q.push_back(e);
            ev_read = 1'b1;
            @(negedge clk);
            ev_read = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ev_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", ev_valid); end
        checks++;
        if (ev_code !== 8'h00) begin errors++; $display("FAIL rst_code got %h want 00", ev_code); end
        checks++;
        if ({ev_ext, ev_release, ev_overflow} !== 3'b000) begin
            errors++; $display("FAIL rst_flags got %b want 000", {ev_ext, ev_release, ev_overflow});
        end
    endtask

    task automatic test_make_break();
        event_t exp[$];
        exp = '{'{code: 8'h1C, ext: 1'b0, rel: 1'b0}, '{code: 8'h1C, ext: 1'b0, rel: 1'b1}};
        got_q.delete();
        @(negedge clk);
        scan_ready = 1'b1;
        scan_code  = 8'h1C;
        checks++;
        if (ev_valid !== 1'b0) begin errors++; $display("FAIL lat_pre got %b want 0", ev_valid); end
        @(negedge clk);
        scan_ready = 1'b0;
        checks++;
        if (ev_valid !== 1'b1 || ev_code !== 8'h1C) begin
            errors++; $display("FAIL lat_n1 got valid %b code %h want 1 1c", ev_valid, ev_code);
        end
        drain();
        send_byte(8'hF0);
        send_byte(8'h1C);
        drain();
        checks++;
        if (got_q.size() != exp.size()) begin
            errors++; $display("FAIL mb_count got %0d want %0d", got_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp[i]) begin errors++; $display("FAIL mb_ev%0d got %h want %h", i, got_q[i], exp[i]); end
        end
    endtask

    task automatic test_extended();
        event_t exp[$];
        exp = '{'{code: 8'h75, ext: 1'b1, rel: 1'b0}, '{code: 8'h75, ext: 1'b1, rel: 1'b1}};
        got_q.delete();
        send_byte(8'hE0); send_byte(8'h75); drain();
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75); drain();
        checks++;
        if (got_q.size() != exp.size()) begin
            errors++; $display("FAIL ext_count got %0d want %0d", got_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp[i]) begin errors++; $display("FAIL ext_ev%0d got %h want %h", i, got_q[i], exp[i]); end
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [8];
        event_t exp[$];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        exp = '{'{code: 8'hE1, ext: 1'b0, rel: 1'b0}, '{code: 8'h1C, ext: 1'b0, rel: 1'b0}};
        do_reset();
        got_q.delete();
        for (int i = 0; i < 8; i++) send_byte(seq[i]);
        drain();
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL pause_count got %0d want 1", got_q.size()); end
        send_byte(8'h1C);
        drain();
        checks++;
        if (got_q.size() != exp.size()) begin
            errors++; $display("FAIL pause_total got %0d want %0d", got_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp[i]) begin errors++; $display("FAIL pause_ev%0d got %h want %h", i, got_q[i], exp[i]); end
        end
    endtask

    task automatic test_held_and_discard();
        do_reset();
        got_q.delete();
        @(negedge clk);
        scan_ready = 1'b1;
        scan_code  = 8'h1C;
        repeat (10) @(negedge clk);
        scan_ready = 1'b0;
        drain();
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL held_count got %0d want 1", got_q.size()); end
        got_q.delete();
        send_byte(8'hAA);
        send_byte(8'hFA);
        drain();
        checks++;
        if (got_q.size() != 0 || ev_valid !== 1'b0) begin
            errors++; $display("FAIL discard got %0d events valid %b want 0 0", got_q.size(), ev_valid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] mk [5];
        logic [7:0] exp [4];
        mk  = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        exp = '{8'h1D, 8'h24, 8'h2D, 8'h35};
        do_reset();
        got_q.delete();
        for (int i = 0; i < 4; i++) send_byte(mk[i]);
        checks++;
        if (ev_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", ev_overflow); end
        send_byte(mk[4]);
        checks++;
        if (ev_overflow !== 1'b1 || ev_valid !== 1'b1 || ev_code !== 8'h15) begin
            errors++; $display("FAIL ovf_set got ovf %b valid %b head %h want 1 1 15", ev_overflow, ev_valid, ev_code);
        end
        // Push and pop in the same cycle while full
        @(negedge clk);
        scan_ready = 1'b1;
        scan_code  = 8'h35;
        ev_read    = 1'b1;
        @(negedge clk);
        scan_ready = 1'b0;
        ev_read    = 1'b0;
        drain();
        checks++;
        if (got_q.size() != 4) begin errors++; $display("FAIL full_pp_count got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].code !== exp[i]) begin
                errors++; $display("FAIL full_pp_ev%0d got %h want %h", i, got_q[i].code, exp[i]);
            end
        end
        checks++;
        if (ev_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ev_overflow); end
    endtask

    task automatic test_typematic();
        event_t exp[$];
`ifdef KEYDEC_TYPEMATIC_FILTER_EN
        exp = '{'{code: 8'h1C, ext: 1'b0, rel: 1'b0}, '{code: 8'h1C, ext: 1'b0, rel: 1'b1},
                '{code: 8'h1C, ext: 1'b0, rel: 1'b0}};
`else
        exp = '{'{code: 8'h1C, ext: 1'b0, rel: 1'b0}, '{code: 8'h1C, ext: 1'b0, rel: 1'b0},
                '{code: 8'h1C, ext: 1'b0, rel: 1'b0}, '{code: 8'h1C, ext: 1'b0, rel: 1'b1},
                '{code: 8'h1C, ext: 1'b0, rel: 1'b0}};
`endif
        do_reset();
        got_q.delete();
        send_byte(8'h1C); drain();
        send_byte(8'h1C); drain();
        send_byte(8'h1C); drain();
        send_byte(8'hF0); send_byte(8'h1C); drain();
        send_byte(8'h1C); drain();
        checks++;
        if (got_q.size() != exp.size()) begin
            errors++; $display("FAIL typ_count got %0d want %0d", got_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp[i]) begin errors++; $display("FAIL typ_ev%0d got %h want %h", i, got_q[i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid();
        event_t exp;
        exp = '{code: 8'h75, ext: 1'b0, rel: 1'b0};
        do_reset();
        got_q.delete();
        send_byte(8'h1C);
        send_byte(8'hE0);
        do_reset();
        checks++;
        if (ev_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", ev_valid); end
        send_byte(8'h75);
        drain();
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL rstmid_count got %0d want 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== exp) begin errors++; $display("FAIL rstmid_ev got %h want %h", got_q[0], exp); end
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_pause();
        test_held_and_discard();
        test_overflow();
        test_typematic();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
